mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter sharing a single 4:1 mux datapath among four requesters.
- Grants one requester at a time and drives the mux select pair (sel_a = MSB, sel_b = LSB) so the mux output carries the granted requester's input.
- Limits how long one requester can hold the mux, which bounds the wait for every other requester.
- Sits between the requesting sources and the 4:1 mux; it never touches data bits.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one grant may last; legal range 1..255.
- CW, 8: hold counter width; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- req, input, 4: request vector; req[i] held high while requester i wants the mux.
- done, input, 1: owner's early release strobe; sampled only in GRANT.
- grant, output, 4: one-hot or zero; grant[i] means the mux is selecting input i.
- sel_a, output, 1: mux select MSB; index = {sel_a, sel_b}.
- sel_b, output, 1: mux select LSB.
- busy, output, 1: high while in GRANT.
- timeout, output, 1: one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- All outputs are registered.
- Reset (async): state=IDLE, grant=0000, sel_a=0, sel_b=0, busy=0, timeout=0, hold_cnt=0, last=3. With last=3, requester 0 has first priority.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE; outputs hold (sel keeps its last value, grant=0).
  - Otherwise pick winner w = the first i with req[i]=1, scanning last+1, last+2, last+3, last+4 (mod 4).
  - Next edge: grant=onehot(w), {sel_a,sel_b}=w, busy=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled high in IDLE to grant high is 1 cycle.
- GRANT, owner o:
  - Each cycle hold_cnt increments.
  - Release conditions, evaluated on the same edge:
    - (a) req[o]==0
    - (b) done==1
    - (c) hold_cnt==MAX_HOLD-1
  - On release: grant=0000, busy=0, last=o, state=IDLE, hold_cnt=0.
  - On release by (c) only, with (a) and (b) false: timeout=1 for exactly that next cycle.
  - sel_a/sel_b stay at o after release until the next grant; the mux select never changes while a grant is active.
  - Requests from non-owners are ignored until re-arbitration.
- Re-arbitration:
  - At least one IDLE cycle (grant=0000) between consecutive grants. This is the bubble during which the mux output is don't-care.
  - The previous owner has lowest priority in the next arbitration, including after a timeout.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. If that requester's req is still high, timeout fires.
- Simultaneous events:
  - done together with req[o] low is a normal release, with no timeout.
  - done on the timeout cycle also suppresses timeout.
- Reset mid-GRANT: grant drops asynchronously and last returns to 3.
- Invariants:
  - grant is always one-hot or zero.
  - When grant≠0, {sel_a,sel_b} equals the index of the set grant bit.

Decomposition:
- Shared package: the state encoding (IDLE=0, GRANT=1) and the default MAX_HOLD constant.
- One natural sub-module: rr_pick4, a combinational priority rotator.
  - Inputs: req[3:0], last[1:0].
  - Outputs: valid, win[1:0].
  - Reusable by other 4-way arbiters.
- The top level holds the FSM, the hold counter and the output registers.

Test Plan:
- Out of reset, req=0001 held -> grant=0001 and sel=00 from cycle 1. With MAX_HOLD=8: grant drops after 8 grant cycles, timeout pulses once, and grant=0001 returns after a 1-cycle bubble (req[0] is the only requester).
- req=1111 constant, done pulsed every grant cycle -> grant order 0001, 0010, 0100, 1000, 0001. sel follows 00, 01, 10, 11, 00. grant=0000 between each grant.
- After grant to 2 (last=2), req=0101 -> next grant=0001 (the scan order is 3, 0, 1, 2).
- req=0010 granted, req[1] deasserted on the 3rd grant cycle -> grant=0000 next edge, timeout stays 0, sel stays 01.
- rst asserted mid-GRANT while grant=0100 -> grant=0000, busy=0 and sel=00 immediately. After rst release with req=0101, the first grant is 0001.
- MAX_HOLD=1 with req=0011 held -> alternating single-cycle grants 0001, 0010 with bubbles between them. timeout pulses after every grant.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int unsigned DEFAULT_MAX_HOLD = 8;
   localparam int unsigned DEFAULT_CW       = 8;

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping mod 4.
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic       valid,
   output logic [1:0] win
);

   logic [2:0] shift;
   logic [7:0] dbl;
   logic [3:0] rot;
   logic [1:0] off;

   // Rotate so that bit 0 of rot is the requester right after 'last'.
   assign shift = {1'b0, last} + 3'd1;
   assign dbl   = {req, req} >> shift;
   assign rot   = dbl[3:0];
   assign valid = |req;

   always_comb begin
      off = 2'd0;
      if (rot[0])      off = 2'd0;
      else if (rot[1]) off = 2'd1;
      else if (rot[2]) off = 2'd2;
      else if (rot[3]) off = 2'd3;
   end

   assign win = last + 2'd1 + off;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pair of a shared 4:1 mux, with a hold limit.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among req using the rotating priority
//   GRANT | one owner holds the mux; release on req drop, done, or hold limit
module mux4_rr_arbiter
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
   parameter int unsigned CW       = DEFAULT_CW
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] grant,
   output logic       sel_a,
   output logic       sel_b,
   output logic       busy,
   output logic       timeout
);

   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   arb_state_t    state;
   logic [CW-1:0] hold_cnt;
   logic [1:0]    last;
   logic [1:0]    sel_q;
   logic          pick_valid;
   logic [1:0]    pick_win;
   logic          rel_own;
   logic          rel_done;
   logic          rel_hold;
   logic          release_now;

   rr_pick4 u_pick (
      .req   (req),
      .last  (last),
      .valid (pick_valid),
      .win   (pick_win)
   );

   // While in GRANT the select register is the owner index.
   always_comb begin
      rel_own     = ~req[sel_q];
      rel_done    = done;
      rel_hold    = (hold_cnt == HOLD_LAST);
      release_now = rel_own | rel_done | rel_hold;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= 4'b0000;
         sel_q    <= 2'd0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         hold_cnt <= '0;
         last     <= 2'd3;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state    <= GRANT;
                  grant    <= 4'b0001 << pick_win;
                  sel_q    <= pick_win;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
               end
            end
            GRANT: begin
               if (release_now) begin
                  state    <= IDLE;
                  grant    <= 4'b0000;
                  busy     <= 1'b0;
                  last     <= sel_q;
                  hold_cnt <= '0;
                  // Forced release only counts as a timeout if nothing else ended the grant.
                  timeout  <= rel_hold & ~rel_own & ~rel_done;
               end else begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sel_a = sel_q[1];
   assign sel_b = sel_q[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (MAX_HOLD=8 and MAX_HOLD=1) against a cycle model.
module tb_mux4_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       done;

   logic [3:0] grant0, grant1;
   logic       sel_a0, sel_b0, busy0, timeout0;
   logic       sel_a1, sel_b1, busy1, timeout1;
   logic [7:0] obs0, obs1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.MAX_HOLD(8), .CW(8)) dut0 (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant(grant0), .sel_a(sel_a0), .sel_b(sel_b0), .busy(busy0), .timeout(timeout0)
   );

   mux4_rr_arbiter #(.MAX_HOLD(1), .CW(4)) dut1 (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant(grant1), .sel_a(sel_a1), .sel_b(sel_b1), .busy(busy1), .timeout(timeout1)
   );

   assign obs0 = {grant0, sel_a0, sel_b0, busy0, timeout0};
   assign obs1 = {grant1, sel_a1, sel_b1, busy1, timeout1};

   // Reference: owner index (-1 = none), number of grant cycles seen so far, last owner.
   int m_owner[2];
   int m_held[2];
   int m_last[2];
   int m_sel[2];
   bit m_to[2];
   int maxh[2] = '{8, 1};

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k] = -1;
         m_held[k]  = 0;
         m_last[k]  = 3;
         m_sel[k]   = 0;
         m_to[k]    = 1'b0;
      end
   endfunction

   function automatic void model_step(logic [3:0] r, logic d);
      int  c;
      bit  a, b, h;
      for (int k = 0; k < 2; k++) begin
         if (m_owner[k] < 0) begin
            m_to[k] = 1'b0;
            for (int j = 1; j <= 4; j++) begin
               c = (m_last[k] + j) % 4;
               if (m_owner[k] < 0 && r[c]) begin
                  m_owner[k] = c;
                  m_sel[k]   = c;
                  m_held[k]  = 1;
               end
            end
         end else begin
            a = (r[m_owner[k]] == 1'b0);
            b = d;
            h = (m_held[k] == maxh[k]);
            m_to[k] = h && !a && !b;
            if (a || b || h) begin
               m_last[k]  = m_owner[k];
               m_owner[k] = -1;
               m_held[k]  = 0;
            end else begin
               m_held[k]++;
            end
         end
      end
   endfunction

   function automatic logic [7:0] exp_vec(int k);
      logic [3:0] g;
      logic [1:0] s;
      g = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
      s = 2'(m_sel[k]);
      return {g, s, (m_owner[k] >= 0), m_to[k]};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step(req, done);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      req  = 4'b0000;
      done = 1'b0;
      model_reset();
      @(negedge clk);
      rst  = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      req  = 4'b1111;
      done = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs0 !== 8'h00) begin errors++; $display("FAIL reset_hold0 got=%b exp=%b", obs0, 8'h00); end
      checks++;
      if (obs1 !== 8'h00) begin errors++; $display("FAIL reset_hold1 got=%b exp=%b", obs1, 8'h00); end
      @(negedge clk);
      req = 4'b0000;
      rst = 1'b0;
   endtask

   task automatic test_single_timeout();
      int to_cnt = 0;
      do_reset();
      req = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL single0 cyc=%0d got=%b exp=%b", i, obs0, exp_vec(0)); end
         checks++;
         if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL single1 cyc=%0d got=%b exp=%b", i, obs1, exp_vec(1)); end
         if (timeout0) to_cnt++;
         if (i == 0) begin
            checks++;
            if (obs0[7:2] !== 6'b0001_00) begin errors++; $display("FAIL first_grant got=%b exp=%b", obs0[7:2], 6'b0001_00); end
         end
         if (i == 8) begin
            checks++;
            if ({grant0, timeout0} !== 5'b0000_1) begin errors++; $display("FAIL hold_timeout got=%b exp=%b", {grant0, timeout0}, 5'b0000_1); end
         end
         if (i == 9) begin
            checks++;
            if (grant0 !== 4'b0001) begin errors++; $display("FAIL regrant got=%b exp=%b", grant0, 4'b0001); end
         end
      end
      checks++;
      if (to_cnt != 2) begin errors++; $display("FAIL timeout_count got=%0d exp=%0d", to_cnt, 2); end
   endtask

   task automatic test_rotation();
      logic [5:0] seen[$];
      logic [5:0] expv[5] = '{6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11, 6'b0001_00};
      do_reset();
      req  = 4'b1111;
      done = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         checks++;
         if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL rot0 cyc=%0d got=%b exp=%b", i, obs0, exp_vec(0)); end
         checks++;
         if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL rot1 cyc=%0d got=%b exp=%b", i, obs1, exp_vec(1)); end
         if (grant0 != 4'b0000) seen.push_back(obs0[7:2]);
      end
      done = 1'b0;
      checks++;
      if (seen.size() != 5) begin
         errors++; $display("FAIL rot_count got=%0d exp=%0d", seen.size(), 5);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (seen[i] !== expv[i]) begin errors++; $display("FAIL rot_order idx=%0d got=%b exp=%b", i, seen[i], expv[i]); end
         end
      end
   endtask

   task automatic test_priority_skip();
      do_reset();
      req = 4'b0100;
      tick();
      req = 4'b0000;
      tick();
      req = 4'b0101;
      tick();
      checks++;
      if (grant0 !== 4'b0001) begin errors++; $display("FAIL skip_prio got=%b exp=%b", grant0, 4'b0001); end
      checks++;
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL skip0 got=%b exp=%b", obs0, exp_vec(0)); end
      checks++;
      if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL skip1 got=%b exp=%b", obs1, exp_vec(1)); end
      req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_early_release();
      do_reset();
      req = 4'b0010;
      tick();
      tick();
      req = 4'b0000;
      tick();
      checks++;
      if ({grant0, sel_a0, sel_b0, timeout0} !== 7'b0000_01_0) begin
         errors++; $display("FAIL early_rel got=%b exp=%b", {grant0, sel_a0, sel_b0, timeout0}, 7'b0000_01_0);
      end
      tick();
      checks++;
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL early_hold0 got=%b exp=%b", obs0, exp_vec(0)); end
      checks++;
      if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL early_hold1 got=%b exp=%b", obs1, exp_vec(1)); end
   endtask

   task automatic test_mid_grant_reset();
      do_reset();
      req = 4'b0100;
      tick();
      tick();
      checks++;
      if (grant0 !== 4'b0100) begin errors++; $display("FAIL pre_rst_grant got=%b exp=%b", grant0, 4'b0100); end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (obs0 !== 8'h00) begin errors++; $display("FAIL async_rst0 got=%b exp=%b", obs0, 8'h00); end
      checks++;
      if (obs1 !== 8'h00) begin errors++; $display("FAIL async_rst1 got=%b exp=%b", obs1, 8'h00); end
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0101;
      tick();
      checks++;
      if (grant0 !== 4'b0001) begin errors++; $display("FAIL post_rst_grant got=%b exp=%b", grant0, 4'b0001); end
      checks++;
      if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL post_rst1 got=%b exp=%b", obs1, exp_vec(1)); end
   endtask

   task automatic test_maxhold1();
      logic [3:0] gexp[8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
      do_reset();
      req = 4'b0011;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({grant1, timeout1} !== {gexp[i], 1'(i % 2)}) begin
            errors++; $display("FAIL mh1 cyc=%0d got=%b exp=%b", i, {grant1, timeout1}, {gexp[i], 1'(i % 2)});
         end
         checks++;
         if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL mh1_big cyc=%0d got=%b exp=%b", i, obs0, exp_vec(0)); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         done = ($urandom_range(0, 5) == 0);
         tick();
         checks++;
         if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL rand0 cyc=%0d got=%b exp=%b", i, obs0, exp_vec(0)); end
         checks++;
         if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL rand1 cyc=%0d got=%b exp=%b", i, obs1, exp_vec(1)); end
         checks++;
         if (grant0 != 4'b0000 && grant0 !== (4'b0001 << {sel_a0, sel_b0})) begin
            errors++; $display("FAIL rand_sel cyc=%0d got=%b exp=%b", i, grant0, 4'b0001 << {sel_a0, sel_b0});
         end
      end
      done = 1'b0;
      req  = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single_timeout();
      test_rotation();
      test_priority_skip();
      test_early_release();
      test_mid_grant_reset();
      test_maxhold1();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
